// File: rtl/path_meas_pkg.sv
// path_meas_pkg: shared FSM state encoding and trial-count constant for path_delay_meter
//   TRIALS  default number of trials per measurement (power of two)
//   state_e measurement controller states
package path_meas_pkg;

    localparam int TRIALS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        MEASURE,
        RECORD,
        DONE
    } state_e;

endpackage

// File: rtl/path_result_sync.sv
// path_result_sync: multi-flop synchronizer for the asynchronous delay-chain output
//   clk, rst  clock and synchronous active-high reset (flops clear to 0)
//   d_i       asynchronous input
//   q_o       synchronized output, STAGES cycles of latency
module path_result_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// path_delay_meter: launch/capture controller timing one delay chain over 2^LOG_TRIALS trials
//   clk, rst        clock and synchronous active-high reset
//   start_i         begin a measurement (accepted only while idle)
//   busy_o          measurement in progress
//   done_o          one-cycle pulse when results are valid
//   timeout_err_o   last measurement aborted on a trial timeout
//   path_input_o    registered drive into the chain
//   path_result_i   asynchronous chain output
//   sum_o           sum of all trial counts
//   min_o, max_o    smallest / largest trial count
module path_delay_meter
    import path_meas_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int LOG_TRIALS     = $clog2(TRIALS),
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int PATH_INVERTS   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        timeout_err_o,
    output logic                        path_input_o,
    input  logic                        path_result_i,
    output logic [CNT_W+LOG_TRIALS-1:0] sum_o,
    output logic [CNT_W-1:0]            min_o,
    output logic [CNT_W-1:0]            max_o
);

    localparam int SUM_W = CNT_W + LOG_TRIALS;
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LOG_TRIALS-1:0] LAST_IDX = LOG_TRIALS'((1 << LOG_TRIALS) - 1);
    localparam logic INV = 1'(PATH_INVERTS);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LOG_TRIALS-1:0]   idx_q, idx_d;
    logic                    pin_q, pin_d;
    logic                    terr_q, terr_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [CNT_W-1:0]        min_q, min_d;
    logic [CNT_W-1:0]        max_q, max_d;
    logic                    rs;
    logic                    matched;
    logic [CNT_W-1:0]        cnt_inc;

    path_result_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (path_result_i),
        .q_o (rs)
    );

    assign matched = rs == (pin_q ^ INV);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // The path_input edge is registered on entry to LAUNCH, so the counter
    // cleared at the end of LAUNCH makes each trial count exactly chain delay
    // plus synchronizer latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pin_d   = pin_q;
        terr_d  = terr_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    terr_d  = 1'b0;
                    sum_d   = '0;
                    min_d   = '1;
                    max_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q >= SETTLE_LAST && matched) begin
                    state_d = LAUNCH;
                    pin_d   = ~pin_q;
                end else if (cnt_q >= TO_CNT) begin
                    state_d = DONE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LAUNCH: begin
                state_d = MEASURE;
                cnt_d   = '0;
            end
            MEASURE: begin
                if (matched) begin
                    state_d = RECORD;
                    cnt_d   = cnt_inc;
                end else if (cnt_q >= TO_CNT) begin
                    state_d = DONE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RECORD: begin
                sum_d = sum_q + SUM_W'(cnt_q);
                min_d = (cnt_q < min_q) ? cnt_q : min_q;
                max_d = (cnt_q > max_q) ? cnt_q : max_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + LOG_TRIALS'(1);
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pin_q   <= 1'b0;
            terr_q  <= 1'b0;
            sum_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            terr_q  <= terr_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    assign busy_o        = state_q inside {SETTLE, LAUNCH, MEASURE, RECORD};
    assign done_o        = state_q == DONE;
    assign timeout_err_o = terr_q;
    assign path_input_o  = pin_q;
    assign sum_o         = sum_q;
    assign min_o         = min_q;
    assign max_o         = max_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// tb_path_delay_meter: randomized self-checking bench with a behavioural delay-chain model
module tb_path_delay_meter;
    import path_meas_pkg::*;

    localparam int CW   = 16;
    localparam int LT   = 4;
    localparam int S    = 2;
    localparam int TO   = 1000;
    localparam int SUMW = CW + LT;
    localparam longint ALL1 = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start[2];
    logic busy[2], done[2], terr[2], pin[2], pres[2];
    logic [SUMW-1:0] sum[2];
    logic [CW-1:0] mn[2], mx[2];

    int   d_rise = 3, d_fall = 3;
    logic stuck_en = 1'b0, stuck_val = 1'b0;
    logic last[2], pin_prev[2];
    int   age[2], toggles[2], dones[2];
    int   passed = 0, total = 0;

    always #5 clk = ~clk;

    path_delay_meter #(.CNT_W(CW), .LOG_TRIALS(LT), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(8),
                       .SYNC_STAGES(S), .PATH_INVERTS(0)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .timeout_err_o(terr[0]), .path_input_o(pin[0]), .path_result_i(pres[0]),
        .sum_o(sum[0]), .min_o(mn[0]), .max_o(mx[0]));

    path_delay_meter #(.CNT_W(CW), .LOG_TRIALS(LT), .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(8),
                       .SYNC_STAGES(S), .PATH_INVERTS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .timeout_err_o(terr[1]), .path_input_o(pin[1]), .path_result_i(pres[1]),
        .sum_o(sum[1]), .min_o(mn[1]), .max_o(mx[1]));

    // Chain model: output follows the input level d cycles after each edge,
    // d chosen by edge direction; d=0 is a purely combinational chain.
    function automatic logic chain(logic p, logic l, int a, int dr, int df, logic inv);
        int dd = p ? dr : df;
        logic lvl;
        if (p != l) lvl = (dd == 0) ? p : l;
        else        lvl = (a >= dd) ? p : ~p;
        return lvl ^ inv;
    endfunction

    always_comb
        for (int k = 0; k < 2; k++)
            pres[k] = stuck_en ? stuck_val : chain(pin[k], last[k], age[k], d_rise, d_fall, k == 1);

    always @(posedge clk)
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                last[k] <= 1'b0;
                age[k]  <= 255;
            end else begin
                last[k] <= pin[k];
                age[k]  <= (pin[k] != last[k]) ? 1 : (age[k] < 255 ? age[k] + 1 : 255);
            end
            pin_prev[k] <= pin[k];
            if (pin[k] != pin_prev[k]) toggles[k] <= toggles[k] + 1;
            if (done[k]) dones[k] <= dones[k] + 1;
        end

    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic model(input logic lvl, output longint esum, output longint emin, output longint emax);
        esum = 0; emin = ALL1; emax = 0;
        for (int i = 0; i < TRIALS; i++) begin
            longint c = longint'(lvl ? d_fall : d_rise) + S;
            esum += c;
            if (c < emin) emin = c;
            if (c > emax) emax = c;
            lvl = ~lvl;
        end
    endtask

    task automatic check_reset(input int k);
        check("rst_busy", busy[k], 0);
        check("rst_done", done[k], 0);
        check("rst_terr", terr[k], 0);
        check("rst_pin", pin[k], 0);
        check("rst_sum", sum[k], 0);
        check("rst_min", mn[k], ALL1);
        check("rst_max", mx[k], 0);
    endtask

    task automatic run(input int k, input bit poke, output int ntog);
        int t0 = toggles[k], d0 = dones[k], low = 0, cyc = 0;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        check("busy_after_start", busy[k], 1);
        while (!done[k] && cyc < 5000) begin
            if (!busy[k]) low++;
            start[k] = poke && cyc == 20;
            @(posedge clk); #1;
            cyc++;
        end
        start[k] = poke;
        check("done_seen", done[k], 1);
        check("busy_in_done", busy[k], 0);
        check("busy_gaps", low, 0);
        @(posedge clk); #1;
        start[k] = 1'b0;
        check("done_width", done[k], 0);
        check("busy_after_done", busy[k], 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", dones[k] - d0, 1);
        ntog = toggles[k] - t0;
    endtask

    task automatic run_model(input int k, input bit poke, input string tag);
        longint es, emn, emx;
        int ntog;
        model(pin[k], es, emn, emx);
        run(k, poke, ntog);
        check({tag, "_sum"}, sum[k], es);
        check({tag, "_min"}, mn[k], emn);
        check({tag, "_max"}, mx[k], emx);
        check({tag, "_terr"}, terr[k], 0);
        check({tag, "_toggles"}, ntog, TRIALS);
    endtask

    initial begin
        int ntog, n, t0, d0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(posedge clk); #1;

        d_rise = 3; d_fall = 3;
        run_model(0, 0, "d3");
        check("d3_sum_abs", sum[0], 80);

        d_rise = 2; d_fall = 6;
        run_model(0, 1, "d2_6");
        check("d2_6_sum_abs", sum[0], 96);

        d_rise = 1; d_fall = 1;
        run_model(1, 0, "inv_d1");
        check("inv_d1_sum_abs", sum[1], 48);

        for (int i = 0; i < 6; i++) begin
            d_rise = $urandom_range(0, 12);
            d_fall = $urandom_range(0, 12);
            run_model(i % 2, i == 3, $sformatf("rnd%0d", i));
        end

        d_rise = 3; d_fall = 3;
        stuck_en = 1'b1; stuck_val = 1'b0;
        run(0, 0, ntog);
        check("to_meas_terr", terr[0], 1);
        check("to_meas_sum", sum[0], 0);
        check("to_meas_min", mn[0], ALL1);
        check("to_meas_max", mx[0], 0);
        check("to_meas_toggles", ntog, 1);
        run(0, 0, ntog);
        check("to_settle_terr", terr[0], 1);
        check("to_settle_sum", sum[0], 0);
        check("to_settle_toggles", ntog, 0);
        repeat (5) @(posedge clk);
        #1;
        check("terr_hold", terr[0], 1);
        stuck_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        t0 = toggles[0];
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        while (toggles[0] - t0 < 6 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_trial5", toggles[0] - t0, 6);
        repeat (2) @(posedge clk);
        #1;
        check("midrun_sum_nonzero", sum[0] != 0, 1);
        d0 = dones[0];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset(0);
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_rst", dones[0] - d0, 0);
        check("idle_after_rst", busy[0], 0);

        run_model(0, 0, "post_rst");
        check("post_rst_sum_abs", sum[0], 80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
